// File: rtl/s3ga_cfg_tx_pkg.sv
// Shared types, width macros and helpers for the S3GA configuration transmitter.
`ifndef S3GA_CFG_TX_MACROS
`define S3GA_CFG_TX_MACROS
`define CNT(n) (((n) > 1) ? $clog2(n) : 1)
`define V(n) [(n)-1:0]
`endif

package s3ga_cfg_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Number of CFG_W beats carried by one host word.
  function automatic int beats(input int host_w, input int cfg_w);
    return host_w / cfg_w;
  endfunction

endpackage

// File: rtl/s3ga_cfg_tx_if.sv
// Host-side bitstream interface: start/len command plus valid/ready word stream.
interface s3ga_cfg_tx_if #(
  parameter int LEN_W  = 16,
  parameter int HOST_W = 30
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [HOST_W-1:0] host_data;
  logic              host_valid;
  logic              host_ready;

  modport master (output start, len, host_data, host_valid, input host_ready);
  modport slave  (input start, len, host_data, host_valid, output host_ready);

endinterface

// File: rtl/s3ga_cfg_ser.sv
// Parallel-in/serial-out gearbox: one HOST_W word in, HOST_W/CFG_W beats out, LSB beat first.
module s3ga_cfg_ser
  import s3ga_cfg_tx_pkg::*;
#(
  parameter int HOST_W = 30,
  parameter int CFG_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic `V(HOST_W) in_data_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  output logic           out_valid_o,
  output logic `V(CFG_W)  out_data_o,
  output logic           empty_o
);

  localparam int BEATS = beats(HOST_W, CFG_W);
  localparam int REM_W = `CNT(BEATS);

  logic `V(HOST_W)   sr_q;
  logic [REM_W-1:0]  rem_q;
  logic              vld_q;
  logic `V(CFG_W)    dout_q;
  logic              load_s;

  // Empty once the final beat of a word is on the output, so the next word can follow without a bubble.
  assign empty_o     = (rem_q == '0);
  assign in_ready_o  = empty_o;
  assign load_s      = in_valid_i & in_ready_o;
  assign out_valid_o = vld_q;
  assign out_data_o  = dout_q;

  // Beat shifter; the beat register holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      rem_q  <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      rem_q <= '0;
      vld_q <= 1'b0;
    end else if (load_s) begin
      dout_q <= in_data_i[CFG_W-1:0];
      sr_q   <= in_data_i >> CFG_W;
      rem_q  <= REM_W'(BEATS - 1);
      vld_q  <= 1'b1;
    end else if (rem_q != '0) begin
      dout_q <= sr_q[CFG_W-1:0];
      sr_q   <= sr_q >> CFG_W;
      rem_q  <= rem_q - REM_W'(1);
      vld_q  <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/s3ga_cfg_tx.sv
// S3GA configuration transmitter: holds grst, streams host words as cfg beats, waits for cfgd.
module s3ga_cfg_tx
  import s3ga_cfg_tx_pkg::*;
#(
  parameter int M       = 4,
  parameter int CFG_W   = 5,
  parameter int HOST_W  = 30,
  parameter int LEN_W   = 16,
  parameter int RST_CYC = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  s3ga_cfg_tx_if.slave         host,
  output logic                 grst,
  output logic [`CNT(M)-1:0]   m,
  output logic                 cfg,
  output logic `V(CFG_W)        cfg_o,
  input  logic                 cfgd,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int MW = `CNT(M);
  localparam int RW = `CNT(RST_CYC);
  localparam int TW = `CNT(TIMEOUT);

  state_e            state_q;
  logic [LEN_W-1:0]  words_q;
  logic [RW-1:0]     rst_cnt_q;
  logic [TW-1:0]     tmr_q;
  logic [MW-1:0]     m_q;
  logic              grst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              load_en_s;
  logic              ser_ready_s;
  logic              ser_empty_s;
  logic              clr_s;
  logic              acc_s;

  // Words are only requested while some remain; an early cfgd flushes the gearbox at once.
  assign load_en_s       = (state_q == S_LOAD) && (words_q != '0);
  assign host.host_ready = load_en_s & ser_ready_s;
  assign acc_s           = host.host_valid & host.host_ready;
  assign clr_s           = (state_q != S_LOAD) | cfgd;

  s3ga_cfg_ser #(
    .HOST_W (HOST_W),
    .CFG_W  (CFG_W)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_s),
    .in_data_i   (host.host_data),
    .in_valid_i  (host.host_valid & load_en_s),
    .in_ready_o  (ser_ready_s),
    .out_valid_o (cfg),
    .out_data_o  (cfg_o),
    .empty_o     (ser_empty_s)
  );

  assign grst = grst_q;
  assign m    = m_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  // Sequencer, context counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      words_q   <= '0;
      rst_cnt_q <= '0;
      tmr_q     <= '0;
      m_q       <= '0;
      grst_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_q    <= (m_q == MW'(M - 1)) ? '0 : m_q + MW'(1);
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host.start) begin
            words_q   <= host.len;
            err_q     <= 1'b0;
            rst_cnt_q <= '0;
            m_q       <= '0;
            grst_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_RESET;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RW'(RST_CYC - 1)) begin
            tmr_q   <= '0;
            state_q <= (words_q == '0) ? S_WAIT : S_LOAD;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        S_LOAD: begin
          if (acc_s) begin
            words_q <= words_q - LEN_W'(1);
          end
          if (cfgd) begin
            grst_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if ((words_q == '0) && ser_empty_s) begin
            tmr_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cfgd) begin
            grst_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            grst_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          grst_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s3ga_cfg_tx.sv
// Scoreboard bench for s3ga_cfg_tx: expected beats queued on each host word, popped on every cfg beat.
module tb_s3ga_cfg_tx;

  localparam int M       = 4;
  localparam int CFG_W   = 5;
  localparam int HOST_W  = 30;
  localparam int LEN_W   = 16;
  localparam int RST_CYC = 8;
  localparam int TIMEOUT = 1024;
  localparam int BEATS   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             grst, cfg, cfgd, busy, done, err;
  logic [1:0]       m;
  logic [CFG_W-1:0] cfg_o;

  int errs = 0;
  int checks = 0;
  int mon_beats = 0;
  logic [CFG_W-1:0] exp_q[$];

  s3ga_cfg_tx_if #(.LEN_W(LEN_W), .HOST_W(HOST_W)) hif ();

  s3ga_cfg_tx #(
    .M(M), .CFG_W(CFG_W), .HOST_W(HOST_W), .LEN_W(LEN_W),
    .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (hif),
    .grst  (grst),
    .m     (m),
    .cfg   (cfg),
    .cfg_o (cfg_o),
    .cfgd  (cfgd),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every beat on cfg_o must match the head of the expected-beat queue.
  always @(negedge clk) begin
    if (rst_n && cfg) begin
      mon_beats++;
      if (exp_q.size() == 0) tb_check("beat_unexpected", 32'(exp_q.size()), 32'd1);
      else tb_check("beat", 32'(cfg_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic start_cfg(input logic [LEN_W-1:0] n);
    @(posedge clk); #1;
    hif.start = 1'b1;
    hif.len   = n;
    @(posedge clk); #1;
    hif.start = 1'b0;
  endtask

  task automatic send_word(input logic [HOST_W-1:0] w);
    int n;
    hif.host_data  = w;
    hif.host_valid = 1'b1;
    for (int i = 0; i < BEATS; i++) exp_q.push_back(w[i*CFG_W +: CFG_W]);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (hif.host_ready) break;
      n++;
    end
    if (n >= 100) tb_check("handshake_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    hif.host_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (hif.host_ready) break;
      n++;
    end
    if (n >= 100) tb_check("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_measure(input int total, output int rst_cyc, output int nbeats, output int gaps);
    rst_cyc = 0;
    nbeats  = 0;
    gaps    = 0;
    for (int n = 0; n < 400 && nbeats < total; n++) begin
      @(negedge clk);
      if (cfg) nbeats++;
      else if (nbeats > 0) gaps++;
      else if (grst && !hif.host_ready) rst_cyc++;
    end
  endtask

  task automatic wait_beats(input int total);
    int seen;
    seen = 0;
    for (int n = 0; n < 200 && seen < total; n++) begin
      @(negedge clk);
      if (cfg) seen++;
    end
    tb_check("beats_before_event", 32'(seen), 32'(total));
  endtask

  task automatic finish_ok(input int dly);
    int n;
    repeat (dly) @(posedge clk);
    #1 cfgd = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    tb_check("done_pulse", 32'(done), 32'd1);
    tb_check("grst_at_done", 32'(grst), 32'd0);
    tb_check("err_at_done", 32'(err), 32'd0);
    @(posedge clk); #1 cfgd = 1'b0;
    @(negedge clk);
    tb_check("done_single", 32'(done), 32'd0);
    tb_check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, nb, gp, n, base;
    logic seen_done, acc;
    hif.start = 1'b0; hif.len = '0; hif.host_data = '0; hif.host_valid = 1'b0; cfgd = 1'b0;

    // Reset state
    #23;
    tb_check("reset_outs", 32'({grst, cfg, cfg_o, m, hif.host_ready, busy, done, err}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic load, len=2, host always valid
    start_cfg(16'd2);
    fork
      begin send_word(30'h3FFF_FFFF); send_word(30'h0000_0021); end
      run_measure(12, rc, nb, gp);
    join
    tb_check("basic_rst_cycles", 32'(rc), 32'(RST_CYC));
    tb_check("basic_beats", 32'(nb), 32'd12);
    tb_check("basic_gaps", 32'(gp), 32'd0);
    @(negedge clk);
    tb_check("wait_outs", 32'({cfg, grst, hif.host_ready, busy}), 32'b0101);
    tb_check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    finish_ok(3);

    // Host stall of 5 cycles between words
    start_cfg(16'd2);
    fork
      begin
        send_word(30'h1234_5678);
        wait_ready();
        repeat (5) @(posedge clk);
        #1;
        send_word(30'h2ABC_DEF1);
      end
      run_measure(12, rc, nb, gp);
    join
    tb_check("stall_beats", 32'(nb), 32'd12);
    tb_check("stall_gaps", 32'(gp), 32'd5);
    tb_check("stall_no_err", 32'(err), 32'd0);
    finish_ok(1);

    // Timeout in WAIT
    start_cfg(16'd1);
    fork
      send_word(30'h0155_5555);
      run_measure(6, rc, nb, gp);
    join
    tb_check("to_beats", 32'(nb), 32'd6);
    @(negedge clk);
    n = 0;
    seen_done = 1'b0;
    while (!err && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (done) seen_done = 1'b1;
    end
    tb_check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    tb_check("timeout_outs", 32'({err, grst, cfg, seen_done}), 32'b1000);
    @(negedge clk);
    tb_check("err_sticky", 32'({err, busy}), 32'b10);

    // len=0: start clears err, m aligned to RESET entry, no beats
    base = mon_beats;
    start_cfg(16'd0);
    @(negedge clk);
    tb_check("err_cleared", 32'(err), 32'd0);
    tb_check("m_reset_entry", 32'(m), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tb_check("m_wrap", 32'(m), 32'(k % M));
    end
    acc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = acc | hif.host_ready | cfg;
    end
    tb_check("len0_no_load", 32'({acc, grst, busy}), 32'b011);
    finish_ok(2);
    tb_check("len0_beats", 32'(mon_beats - base), 32'd0);

    // Early cfgd during the 3rd beat
    start_cfg(16'd2);
    fork
      send_word(30'h0A5A_5A5A);
      begin wait_beats(3); cfgd = 1'b1; end
    join
    @(negedge clk);
    tb_check("early_outs", 32'({err, cfg, hif.host_ready, grst}), 32'b1000);
    cfgd = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tb_check("early_idle", 32'({err, busy}), 32'b10);

    // Async reset mid-LOAD, then a clean rerun
    start_cfg(16'd2);
    fork
      send_word(30'h3C3C_3C3C);
      wait_beats(4);
    join
    #2 rst_n = 1'b0;
    #1;
    tb_check("async_rst_outs", 32'({grst, cfg, cfg_o, m, hif.host_ready, busy, done, err}), 32'd0);
    exp_q.delete();
    hif.host_valid = 1'b1;
    hif.host_data  = 30'h1555_AAAA;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = acc | hif.host_ready | busy | cfg;
    end
    tb_check("post_rst_idle", 32'(acc), 32'd0);
    hif.host_valid = 1'b0;
    start_cfg(16'd1);
    fork
      send_word(30'h0765_4321);
      run_measure(6, rc, nb, gp);
    join
    tb_check("rerun_rst_cycles", 32'(rc), 32'(RST_CYC));
    tb_check("rerun_beats", 32'(nb), 32'd6);
    finish_ok(2);
    tb_check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/s3ga_cfg_tx.md
Name: s3ga_cfg_tx

Overview:
- Configuration transmitter: the source end of the cluster configuration interface (cfg, cfg_i, cfgd, grst, m).
- Accepts HOST_W-bit bitstream words from a host over a valid/ready handshake and holds the fabric in global reset.
- Serializes each word into CFG_W-bit beats on cfg_o, qualified by cfg, then waits for the top cluster's cfgd before releasing grst.
- Also generates the free-running context counter m (cycle % M).

Parameters:
- M, 4, contexts; m counts 0..M-1.
- CFG_W, 5, config beat width; matches the cluster's cfg_i width.
- HOST_W, 30, host word width; must be a multiple of CFG_W. BEATS = HOST_W/CFG_W = 6.
- LEN_W, 16, width of the host word count.
- RST_CYC, 8, cycles grst is held before the first beat (≥1).
- TIMEOUT, 1024, max cycles in WAIT for cfgd (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin configuration (sampled only in IDLE)
- len  in  LEN_W  number of host words, sampled with start
- host_data  in  HOST_W  bitstream word
- host_valid  in  1  host_data valid
- host_ready  out  1  word accepted when host_valid & host_ready
- grst  out  1  S3GA configuration in progress
- m  out  `CNT(M)  cycle % M
- cfg  out  1  config beat enable
- cfg_o  out  CFG_W  config beat, drives cluster cfg_i
- cfgd  in  1  configured, from the top cluster
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on success
- err  out  1  sticky error; cleared by the next accepted start

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs are 0: grst, cfg, cfg_o, m, host_ready, busy, done, err. The shift register and counters clear. Reset is allowed mid-operation: everything aborts with no done pulse.
- m:
  - Increments every cycle, wrapping M-1 -> 0.
  - Is forced to 0 in the cycle of entering RESET, so context 0 aligns with configuration start.
- States: IDLE, RESET, LOAD, WAIT, DONE, ERR.
- IDLE:
  - grst=0.
  - On start=1: latch len, clear err, go to RESET.
  - start in any other state is ignored.
- RESET:
  - grst=1.
  - Count RST_CYC cycles, then go to LOAD. If len==0, go to WAIT instead.
- LOAD:
  - grst=1.
  - host_ready=1 only while the shift register is empty. A word loads when host_valid & host_ready.
  - The cycle after a load, emit beat 0 = word[CFG_W-1:0] with cfg=1.
  - Each following cycle shifts right by CFG_W: beat i = word[i*CFG_W +: CFG_W].
  - host_ready rises in the cycle the last beat (BEATS-1) is on cfg_o, so back-to-back words stream with no bubble: cfg stays high continuously.
  - Host stall (host_valid=0 with the register empty): cfg=0, cfg_o holds its last value. This is legal and is not an error.
  - After beat BEATS-1 of word len-1, go to WAIT.
- Early cfgd: cfgd=1 at any time in LOAD -> ERR.
- WAIT:
  - grst=1, cfg=0, host_ready=0, and the timeout counter runs.
  - cfgd=1 -> DONE.
  - Counter reaches TIMEOUT -> ERR.
  - If both happen in the same cycle, cfgd wins.
- DONE: grst=0, done=1 for exactly one cycle, then IDLE.
- ERR: grst=0, err=1 (sticky), then IDLE.
- cfg_o is registered, so cfg and cfg_o change on the same clock edge. Beat latency from accepted word to first beat is 1 cycle.
- Total cfg beats = len*BEATS. No beat is emitted outside LOAD.

Decomposition:
- Shared package: the state enum, a BEATS constant function, and the `CNT/`V width macros from s3ga.h.
- One natural sub-module: s3ga_cfg_ser. It is a parallel-in/serial-out gearbox (HOST_W -> CFG_W) with in-side valid/ready and out-side valid, and it owns the beat counter and the empty flag.
- The FSM, m counter and timeout counter stay in the top.

Test Plan:
- Basic load: start, len=2, words 0x3FFFFFFF then 0x00000021, host always valid -> grst high for 8 cycles, then 12 consecutive cfg beats. Beats are 0x1F×6, then 0x01, 0x01, 0x00, 0x00, 0x00, 0x00. With cfgd raised 3 cycles later: done pulse, grst=0.
- Host stall: host_valid low for 5 cycles between words -> cfg=0 for those 5 cycles, beat order intact, 12 beats total, no err.
- Timeout: len=1, cfgd never asserted -> ERR exactly TIMEOUT cycles after entering WAIT; err=1, grst=0, no done. A new start clears err.
- Early cfgd: cfgd=1 during the 3rd beat -> err=1, cfg=0 from the next cycle, host_ready=0.
- len=0 and m: start with len=0 -> zero cfg beats, WAIT entered directly. Check that m reads 0 on the RESET entry cycle and then wraps 0,1,2,3,0.
- Async reset mid-LOAD: rst_n low on beat 4 -> all outputs 0 immediately. After release, the block sits in IDLE, ignores host_valid, and a new start re-runs cleanly.
